// File: rtl/pb_mailbox_pkg.sv
// Shared constants for the PicoBlaze mailbox: register offsets, STATUS and
// CTRL bit positions, and small helpers used by the port decode.
package pb_mailbox_pkg;

   // Register offsets relative to each side's port_id base.
   typedef enum logic [7:0] {
      OFS_DATA   = 8'd0,
      OFS_STATUS = 8'd1,
      OFS_CTRL   = 8'd2,
      OFS_COUNT  = 8'd3
   } pb_ofs_e;

   // STATUS register bit positions.
   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_TX_FULL   = 1;
   localparam int ST_IRQ_EN    = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_UNF       = 4;

   // CTRL register bit positions.
   localparam int CT_IRQ_EN = 0;
   localparam int CT_CLEAR  = 1;
   localparam int CT_FLUSH  = 2;

   // Absolute port_id of a register; the sum wraps inside the 8-bit space.
   function automatic logic [7:0] port_addr(input logic [7:0] base, input pb_ofs_e ofs);
      return base + 8'(ofs);
   endfunction

   // Occupancy as seen by software: a 256-deep FIFO that is full reads as FF.
   function automatic logic [7:0] sat_byte(input int unsigned n);
      return (n > 32'd255) ? 8'hFF : n[7:0];
   endfunction

endpackage

// File: rtl/pb_mbox_fifo.sv
// Byte FIFO with occupancy count and synchronous flush. A push is accepted at
// full only when a pop happens in the same cycle; a pop at empty is ignored,
// so there is no bypass from din to dout. Flush beats both push and pop.
module pb_mbox_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;
   logic          do_push;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; empty/count guard every read, so
      // stale contents are never observed and the array can map to RAM.
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pb_mailbox.sv
// Bidirectional mailbox between two KCPSM3 I/O buses. Each side owns a DATA,
// STATUS, CTRL and COUNT register at its own port_id base. Index 0 is side A
// and index 1 is side B; FIFO f carries bytes written by side f to side 1-f.
module pb_mailbox
   import pb_mailbox_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] A_BASE    = 8'h00,
   parameter logic [7:0] B_BASE    = 8'h00,
   parameter int         IRQ_LEVEL = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a_port_id,
   input  logic [7:0] a_out_port,
   input  logic       a_write_strobe,
   input  logic       a_read_strobe,
   output logic [7:0] a_in_port,
   output logic       a_interrupt,
   input  logic       a_interrupt_ack,
   input  logic [7:0] b_port_id,
   input  logic [7:0] b_out_port,
   input  logic       b_write_strobe,
   input  logic       b_read_strobe,
   output logic [7:0] b_in_port,
   output logic       b_interrupt,
   input  logic       b_interrupt_ack
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] IRQ_THR = (CW+1)'(IRQ_LEVEL);

   logic [7:0]    port_id  [2];
   logic [7:0]    out_port [2];
   logic [7:0]    base     [2];
   logic [1:0]    wr_stb;
   logic [1:0]    rd_stb;
   logic [1:0]    ack;

   logic [1:0]    wr_data;
   logic [1:0]    rd_data;
   logic [1:0]    ctrl_wr;
   logic [1:0]    fifo_push;
   logic [1:0]    fifo_pop;
   logic [1:0]    fifo_flush;
   logic [1:0]    full;
   logic [1:0]    empty;
   logic [1:0]    pop_ok;
   logic [1:0]    push_ok;
   logic [1:0]    irq_set;
   logic [7:0]    dout     [2];
   logic [CW-1:0] count    [2];
   logic [CW:0]   cnt_next [2];
   logic [7:0]    rd_mux   [2];

   logic [7:0]    in_port_q [2];
   logic [1:0]    irq_flag;
   logic [1:0]    irq_en;
   logic [1:0]    ovf;
   logic [1:0]    unf;

   assign port_id[0]  = a_port_id;
   assign port_id[1]  = b_port_id;
   assign out_port[0] = a_out_port;
   assign out_port[1] = b_out_port;
   assign base[0]     = A_BASE;
   assign base[1]     = B_BASE;
   assign wr_stb      = {b_write_strobe, a_write_strobe};
   assign rd_stb      = {b_read_strobe, a_read_strobe};
   assign ack         = {b_interrupt_ack, a_interrupt_ack};

   // Strobe-qualified address decode, each side against its own base only.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block can leave it unassigned and infer a latch.
      wr_data = '0;
      rd_data = '0;
      ctrl_wr = '0;
      for (int s = 0; s < 2; s++) begin
         wr_data[s] = wr_stb[s] & (port_id[s] == port_addr(base[s], OFS_DATA));
         rd_data[s] = rd_stb[s] & (port_id[s] == port_addr(base[s], OFS_DATA));
         ctrl_wr[s] = wr_stb[s] & (port_id[s] == port_addr(base[s], OFS_CTRL));
      end
   end

   // Side f pushes into FIFO f; the peer side pops it; CTRL flushes own tx.
   assign fifo_push     = wr_data;
   assign fifo_pop      = {rd_data[0], rd_data[1]};
   assign fifo_flush[0] = ctrl_wr[0] & out_port[0][CT_FLUSH];
   assign fifo_flush[1] = ctrl_wr[1] & out_port[1][CT_FLUSH];

   for (genvar f = 0; f < 2; f++) begin : g_fifo
      pb_mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (fifo_push[f]),
         .pop   (fifo_pop[f]),
         .flush (fifo_flush[f]),
         .din   (out_port[f]),
         .dout  (dout[f]),
         .full  (full[f]),
         .empty (empty[f]),
         .count (count[f])
      );
   end

   // Accepted FIFO operations and post-edge occupancy drive the interrupt set.
   always_comb begin
      pop_ok  = '0;
      push_ok = '0;
      irq_set = '0;
      for (int f = 0; f < 2; f++) begin
         pop_ok[f]   = fifo_pop[f] & ~empty[f] & ~fifo_flush[f];
         push_ok[f]  = fifo_push[f] & ~fifo_flush[f] & (~full[f] | pop_ok[f]);
         cnt_next[f] = (CW+1)'(count[f]) + (CW+1)'(push_ok[f]) - (CW+1)'(pop_ok[f]);
      end
      for (int s = 0; s < 2; s++) begin
         irq_set[s] = push_ok[1-s] & irq_en[s] & (cnt_next[1-s] >= IRQ_THR);
      end
   end

   // Read-data mux per side, selected by the current port_id every cycle.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         rd_mux[s] = 8'h00;
         if (port_id[s] == port_addr(base[s], OFS_DATA)) begin
            rd_mux[s] = empty[1-s] ? 8'h00 : dout[1-s];
         end else if (port_id[s] == port_addr(base[s], OFS_STATUS)) begin
            rd_mux[s][ST_RX_NEMPTY] = ~empty[1-s];
            rd_mux[s][ST_TX_FULL]   = full[s];
            rd_mux[s][ST_IRQ_EN]    = irq_en[s];
            rd_mux[s][ST_OVF]       = ovf[s];
            rd_mux[s][ST_UNF]       = unf[s];
         end else if (port_id[s] == port_addr(base[s], OFS_CTRL)) begin
            rd_mux[s][CT_IRQ_EN] = irq_en[s];
         end else if (port_id[s] == port_addr(base[s], OFS_COUNT)) begin
            rd_mux[s] = sat_byte(32'(count[1-s]));
         end
      end
   end

   // Registered in_port, sticky error flags, irq enable and interrupt flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) in_port_q[s] <= 8'h00;
         irq_flag <= '0;
         irq_en   <= '1;
         ovf      <= '0;
         unf      <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            in_port_q[s] <= rd_mux[s];
            if (irq_set[s])  irq_flag[s] <= 1'b1;
            else if (ack[s]) irq_flag[s] <= 1'b0;
            if (ctrl_wr[s]) begin
               irq_en[s] <= out_port[s][CT_IRQ_EN];
               if (out_port[s][CT_CLEAR]) begin
                  ovf[s] <= 1'b0;
                  unf[s] <= 1'b0;
               end
            end
            // A write and a CTRL write from the same side never coincide, so
            // setting here cannot race the clear above.
            if (wr_data[s] & full[s] & ~rd_data[1-s]) ovf[s] <= 1'b1;
            if (rd_data[s] & empty[1-s])              unf[s] <= 1'b1;
         end
      end
   end

   assign a_in_port   = in_port_q[0];
   assign b_in_port   = in_port_q[1];
   assign a_interrupt = irq_flag[0];
   assign b_interrupt = irq_flag[1];

endmodule

// File: tb/tb_pb_mailbox.sv
// Scoreboard bench for pb_mailbox. Two instances share all inputs and differ
// only in IRQ_LEVEL (1 and 4). The driver updates a queue-based model each
// cycle and enqueues expected read data and interrupt levels; a monitor pops
// and compares whenever the DUT presents them.
module tb_pb_mailbox;

   localparam int         DEPTH  = 16;
   localparam logic [7:0] A_BASE = 8'h20;
   localparam logic [7:0] B_BASE = 8'h40;
   localparam int         L0     = 1;
   localparam int         L1     = 4;
   localparam int         K_IDLE = 0;
   localparam int         K_WR   = 1;
   localparam int         K_RD   = 2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] port;
      logic [7:0] data;
   } act_t;

   localparam act_t IDLE = '0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] a_port_id = '0, a_out_port = '0, b_port_id = '0, b_out_port = '0;
   logic       a_write_strobe = 1'b0, a_read_strobe = 1'b0, a_interrupt_ack = 1'b0;
   logic       b_write_strobe = 1'b0, b_read_strobe = 1'b0, b_interrupt_ack = 1'b0;
   logic [7:0] a_in_port, b_in_port, a_in_port4, b_in_port4;
   logic       a_interrupt, b_interrupt, a_interrupt4, b_interrupt4;

   always #5 clk = ~clk;

   pb_mailbox #(.DEPTH(DEPTH), .A_BASE(A_BASE), .B_BASE(B_BASE), .IRQ_LEVEL(L0)) u_dut (
      .clk(clk), .reset(reset),
      .a_port_id(a_port_id), .a_out_port(a_out_port), .a_write_strobe(a_write_strobe),
      .a_read_strobe(a_read_strobe), .a_in_port(a_in_port), .a_interrupt(a_interrupt),
      .a_interrupt_ack(a_interrupt_ack),
      .b_port_id(b_port_id), .b_out_port(b_out_port), .b_write_strobe(b_write_strobe),
      .b_read_strobe(b_read_strobe), .b_in_port(b_in_port), .b_interrupt(b_interrupt),
      .b_interrupt_ack(b_interrupt_ack)
   );

   pb_mailbox #(.DEPTH(DEPTH), .A_BASE(A_BASE), .B_BASE(B_BASE), .IRQ_LEVEL(L1)) u_dut4 (
      .clk(clk), .reset(reset),
      .a_port_id(a_port_id), .a_out_port(a_out_port), .a_write_strobe(a_write_strobe),
      .a_read_strobe(a_read_strobe), .a_in_port(a_in_port4), .a_interrupt(a_interrupt4),
      .a_interrupt_ack(a_interrupt_ack),
      .b_port_id(b_port_id), .b_out_port(b_out_port), .b_write_strobe(b_write_strobe),
      .b_read_strobe(b_read_strobe), .b_in_port(b_in_port4), .b_interrupt(b_interrupt4),
      .b_interrupt_ack(b_interrupt_ack)
   );

   // Reference model: mq[0] holds bytes A->B, mq[1] bytes B->A.
   logic [7:0] mq [2][$];
   bit         m_en  [2];
   bit         m_ovf [2];
   bit         m_unf [2];
   bit         m_irq [2][2];   // [level index][side]

   logic [7:0] exp_rd [2][$];
   logic [3:0] irq_q [$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int lvl(input int l);
      return (l == 0) ? L0 : L1;
   endfunction

   function automatic logic [7:0] base_of(input int s);
      return (s == 0) ? A_BASE : B_BASE;
   endfunction

   function automatic act_t mk(input int kind, input int side, input int ofs, input int data);
      act_t t;
      t.kind = 2'(kind);
      t.port = base_of(side) + 8'(ofs);
      t.data = 8'(data);
      return t;
   endfunction

   function automatic logic [7:0] model_read(input int s, input logic [7:0] port);
      logic [7:0] d;
      logic [7:0] v;
      int         r;
      r = 1 - s;
      d = port - base_of(s);
      case (d)
         8'd0:    v = (mq[r].size() != 0) ? mq[r][0] : 8'h00;
         8'd1:    v = {3'b000, m_unf[s], m_ovf[s], m_en[s],
                       mq[s].size() == DEPTH, mq[r].size() != 0};
         8'd2:    v = {7'b0, m_en[s]};
         8'd3:    v = 8'(mq[r].size());
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // One clock of stimulus: drive at the falling edge, advance the model.
   task automatic step(input act_t a_act, input act_t b_act,
                       input logic ack_a, input logic ack_b, input logic rst);
      act_t       act [2];
      logic [7:0] d;
      bit         push_req [2], pop_req [2], flush_req [2], ctrl_req [2];
      bit         set_irq [2][2];
      bit         pop_ok, push_ok;
      int         pre;
      @(negedge clk);
      reset           = rst;
      a_port_id       = a_act.port;
      a_out_port      = a_act.data;
      a_write_strobe  = (a_act.kind == 2'(K_WR));
      a_read_strobe   = (a_act.kind == 2'(K_RD));
      a_interrupt_ack = ack_a;
      b_port_id       = b_act.port;
      b_out_port      = b_act.data;
      b_write_strobe  = (b_act.kind == 2'(K_WR));
      b_read_strobe   = (b_act.kind == 2'(K_RD));
      b_interrupt_ack = ack_b;
      act[0] = a_act;
      act[1] = b_act;
      for (int i = 0; i < 2; i++) begin
         push_req[i] = 0; pop_req[i] = 0; flush_req[i] = 0; ctrl_req[i] = 0;
         set_irq[0][i] = 0; set_irq[1][i] = 0;
      end
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_en[i] = 1; m_ovf[i] = 0; m_unf[i] = 0;
            m_irq[0][i] = 0; m_irq[1][i] = 0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            d = act[s].port - base_of(s);
            if (act[s].kind == 2'(K_RD)) begin
               exp_rd[s].push_back(model_read(s, act[s].port));
               if (d == 8'd0) pop_req[1-s] = 1;
            end
            if (act[s].kind == 2'(K_WR)) begin
               if (d == 8'd0) push_req[s] = 1;
               if (d == 8'd2) begin
                  ctrl_req[s]  = 1;
                  flush_req[s] = act[s].data[2];
               end
            end
         end
         for (int f = 0; f < 2; f++) begin
            pre = mq[f].size();
            if (push_req[f] && pre == DEPTH && !pop_req[f]) m_ovf[f] = 1;
            if (pop_req[f] && pre == 0) m_unf[1-f] = 1;
            if (flush_req[f]) begin
               mq[f].delete();
            end else begin
               pop_ok  = pop_req[f] && pre > 0;
               push_ok = push_req[f] && (pre < DEPTH || pop_ok);
               if (pop_ok)  void'(mq[f].pop_front());
               if (push_ok) mq[f].push_back(act[f].data);
               for (int l = 0; l < 2; l++)
                  if (push_ok && m_en[1-f] && mq[f].size() >= lvl(l)) set_irq[l][1-f] = 1;
            end
         end
         for (int s = 0; s < 2; s++) begin
            if (ctrl_req[s]) begin
               m_en[s] = act[s].data[0];
               if (act[s].data[1]) begin m_ovf[s] = 0; m_unf[s] = 0; end
            end
         end
         for (int l = 0; l < 2; l++) begin
            if (set_irq[l][0]) m_irq[l][0] = 1; else if (ack_a) m_irq[l][0] = 0;
            if (set_irq[l][1]) m_irq[l][1] = 1; else if (ack_b) m_irq[l][1] = 0;
         end
      end
      irq_q.push_back({m_irq[1][1], m_irq[1][0], m_irq[0][1], m_irq[0][0]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(IDLE, IDLE, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(IDLE, IDLE, 1'b0, 1'b0, 1'b1);
      step(IDLE, IDLE, 1'b0, 1'b0, 1'b1);
   endtask

   // Direct look at every output right after a reset edge.
   task automatic outputs_zero(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_a_in_port"}, a_in_port, 0);
      check({tag, "_b_in_port"}, b_in_port, 0);
      check({tag, "_a_interrupt"}, a_interrupt, 0);
      check({tag, "_b_interrupt"}, b_interrupt, 0);
      check({tag, "_b_interrupt4"}, b_interrupt4, 0);
   endtask

   function automatic act_t rnd_act(input int side, input int bias);
      int   r;
      int   c;
      act_t t;
      r = int'($urandom_range(0, 99));
      if (r < bias) t = mk(K_WR, side, 0, int'($urandom_range(0, 255)));
      else if (r < 80) t = mk(K_RD, side, 0, 0);
      else if (r < 88) t = mk(K_RD, side, int'($urandom_range(1, 3)), 0);
      else if (r < 91) begin
         t = IDLE;
         t.kind = 2'(K_RD);
         t.port = 8'($urandom_range(0, 255));
      end else if (r < 94) begin
         c = (($urandom_range(0, 3) == 0) ? 4 : 0) | (int'($urandom_range(0, 1)) << 1) |
             (($urandom_range(0, 3) != 0) ? 1 : 0);
         t = mk(K_WR, side, 2, c);
      end else t = IDLE;
      return t;
   endfunction

   // Monitor: interrupts are compared every modelled cycle, in_port after reads.
   initial begin : monitor
      logic [1:0] rs;
      logic [3:0] ei;
      logic [7:0] e;
      bit         have;
      forever begin
         @(posedge clk);
         rs   = {b_read_strobe, a_read_strobe};
         have = (irq_q.size() != 0);
         if (have) ei = irq_q.pop_front();
         #1;
         if (have) begin
            check("a_interrupt_l1", a_interrupt, ei[0]);
            check("b_interrupt_l1", b_interrupt, ei[1]);
            check("a_interrupt_l4", a_interrupt4, ei[2]);
            check("b_interrupt_l4", b_interrupt4, ei[3]);
         end
         for (int s = 0; s < 2; s++) begin
            if (rs[s]) begin
               if (exp_rd[s].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rd_side%0d: read seen with no expected entry at %0t", s, $time);
               end else begin
                  e = exp_rd[s].pop_front();
                  check(s == 0 ? "a_in_port" : "b_in_port", s == 0 ? a_in_port : b_in_port, e);
                  check(s == 0 ? "a_in_port4" : "b_in_port4", s == 0 ? a_in_port4 : b_in_port4, e);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int ba;
      int bb;
      // Reset state and post-reset register values.
      do_reset();
      outputs_zero("reset");
      step(mk(K_RD, 0, 1, 0), mk(K_RD, 1, 1, 0), 1'b0, 1'b0, 1'b0);
      step(mk(K_RD, 0, 3, 0), mk(K_RD, 1, 2, 0), 1'b0, 1'b0, 1'b0);

      // Single byte A->B, status, read, interrupt held until ack.
      step(mk(K_WR, 0, 0, 8'h5A), IDLE, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(IDLE, mk(K_RD, 1, 1, 0), 1'b0, 1'b0, 1'b0);
      step(IDLE, mk(K_RD, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(2);
      step(IDLE, IDLE, 1'b0, 1'b1, 1'b0);
      idle(1);

      // Overflow on DEPTH+1 pushes, ordered drain, underflow.
      do_reset();
      for (int i = 0; i <= DEPTH; i++) step(mk(K_WR, 0, 0, i), IDLE, 1'b0, 1'b0, 1'b0);
      step(mk(K_RD, 0, 1, 0), mk(K_RD, 1, 3, 0), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= DEPTH; i++) step(IDLE, mk(K_RD, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      step(mk(K_RD, 0, 1, 0), mk(K_RD, 1, 1, 0), 1'b0, 1'b0, 1'b0);
      step(IDLE, mk(K_WR, 1, 2, 3), 1'b0, 1'b0, 1'b0);
      step(IDLE, mk(K_RD, 1, 1, 0), 1'b0, 1'b0, 1'b0);

      // Push and pop together at full.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(mk(K_WR, 0, 0, 8'h80 + i), IDLE, 1'b0, 1'b0, 1'b0);
      step(mk(K_WR, 0, 0, 8'hA5), mk(K_RD, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      step(mk(K_RD, 0, 1, 0), mk(K_RD, 1, 3, 0), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(IDLE, mk(K_RD, 1, 0, 0), 1'b0, 1'b0, 1'b0);

      // Threshold interrupt, ack colliding with a further push.
      do_reset();
      for (int i = 0; i < 3; i++) step(mk(K_WR, 0, 0, 8'h10 + i), IDLE, 1'b0, 1'b0, 1'b0);
      idle(2);
      step(mk(K_WR, 0, 0, 8'h13), IDLE, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(mk(K_WR, 0, 0, 8'h14), IDLE, 1'b0, 1'b1, 1'b0);
      idle(1);
      step(IDLE, IDLE, 1'b0, 1'b1, 1'b0);
      idle(1);

      // Interrupt disabled, no replay on re-enable, flush from the sender.
      do_reset();
      step(IDLE, mk(K_WR, 1, 2, 0), 1'b0, 1'b0, 1'b0);
      step(mk(K_WR, 0, 0, 8'h33), IDLE, 1'b0, 1'b0, 1'b0);
      idle(2);
      step(IDLE, mk(K_WR, 1, 2, 1), 1'b0, 1'b0, 1'b0);
      idle(2);
      step(mk(K_WR, 0, 2, 8'h04), mk(K_RD, 1, 3, 0), 1'b0, 1'b0, 1'b0);
      step(IDLE, mk(K_RD, 1, 3, 0), 1'b0, 1'b0, 1'b0);
      step(IDLE, mk(K_RD, 1, 0, 0), 1'b0, 1'b0, 1'b0);

      // Reset with bytes queued and an interrupt pending.
      do_reset();
      for (int i = 0; i < 5; i++) step(mk(K_WR, 0, 0, 8'hC0 + i), IDLE, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(IDLE, IDLE, 1'b0, 1'b0, 1'b1);
      outputs_zero("midreset");
      step(mk(K_RD, 0, 1, 0), mk(K_RD, 1, 3, 0), 1'b0, 1'b0, 1'b0);
      step(mk(K_RD, 0, 3, 0), mk(K_RD, 1, 1, 0), 1'b0, 1'b0, 1'b0);

      // Randomized traffic alternating fill-heavy and drain-heavy phases.
      for (int c = 0; c < 4000; c++) begin
         ba = ((c / 150) % 2 == 0) ? 60 : 10;
         bb = ((c / 230) % 2 == 0) ? 60 : 10;
         if ($urandom_range(0, 1499) == 0)
            step(IDLE, IDLE, 1'b0, 1'b0, 1'b1);
         else
            step(rnd_act(0, ba), rnd_act(1, bb),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15, 1'b0);
      end

      idle(3);
      @(posedge clk);
      #2;
      check("leftover_a", exp_rd[0].size(), 0);
      check("leftover_b", exp_rd[1].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
